monster_sprite_gen: RTL



---
 rtl/monster_sprite_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/monster_sprite_gen.sv
// Purpose: monster sprite pixel source. Owns patrol motion, hit points, hurt-flash blinking and death.
// Latency: 2 clk from h_cnt/v_cnt to pixel_monster (ROM read plus output register).
// Backpressure: none. The pixel stream is free-running. enable=0 freezes per-frame state updates only.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   h_cnt, v_cnt     - VGA scan position
//   valid            - VGA active-area flag
//   enable           - game running
//   hit              - one-clk weapon-hit pulse
//   rom_addr         - combinational sprite ROM address
//   rom_data         - ROM data, returned 1 clk after rom_addr
//   pixel_monster    - pixel to the mixer (0 = none)
//   monster_x/_y     - registered top-left position
//   alive            - 1 while not dead
//   dead_pulse       - one-clk pulse on entering DEAD
module monster_sprite_gen #(
  parameter int          X_INIT       = 200,
  parameter int          Y_INIT       = 240,
  parameter int          X_MIN        = 40,
  parameter int          X_MAX        = 568,
  parameter int          SPEED        = 2,
  parameter int          HP_INIT      = 3,
  parameter int          FLASH_FRAMES = 16,
  parameter int          SPR_W        = 32,
  parameter int          SPR_H        = 32,
  parameter logic [11:0] KEY_COLOR    = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        enable,
  input  logic        hit,
  output logic [9:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pixel_monster,
  output logic [9:0]  monster_x,
  output logic [9:0]  monster_y,
  output logic        alive,
  output logic        dead_pulse
);

  localparam int XW = $clog2(SPR_W);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {PATROL_R, PATROL_L, HURT, DEAD} state_t;

  state_t        state, state_nx;
  logic [9:0]    x_q, x_nx, y_q;
  logic          dir_r, dir_nx;          // 1 = heading right
  logic [3:0]    hp, hp_nx;
  logic [FW-1:0] flash_cnt, flash_nx;
  logic          hit_pending, hit_pending_nx, hit_ok, hit_eff;
  logic          cond, cond_q, cond_qq, frame_tick;
  logic          in_box, blink_on, draw_q;
  logic [9:0]    rel_x, rel_y;

  // Frame boundary detect. Registering cond and edge-detecting it gives one
  // tick per frame even when the pixel counters hold for several clocks.
  assign cond       = (v_cnt == 10'd480) && (h_cnt == 10'd0);
  assign frame_tick = cond_q & ~cond_qq;

  // Compare in 11 bits so the box edge cannot wrap near the right of the screen.
  assign in_box = valid &&
                  ({1'b0, h_cnt} >= {1'b0, x_q}) &&
                  ({1'b0, h_cnt} <  ({1'b0, x_q} + 11'(SPR_W))) &&
                  ({1'b0, v_cnt} >= {1'b0, y_q}) &&
                  ({1'b0, v_cnt} <  ({1'b0, y_q} + 11'(SPR_H)));

  assign rel_x    = h_cnt - x_q;
  assign rel_y    = v_cnt - y_q;
  // SPR_W is a power of two, so the row multiply is a shift.
  assign rom_addr = in_box ? ((rel_y << XW) + rel_x) : 10'd0;

  assign alive    = (state != DEAD);
  assign blink_on = (state == HURT) ? ~flash_cnt[1] : 1'b1;

  assign monster_x = x_q;
  assign monster_y = y_q;

  // A hit pulse in the same clk as frame_tick is folded in before evaluation.
  assign hit_ok  = hit && enable && ((state == PATROL_R) || (state == PATROL_L));
  assign hit_eff = hit_pending | hit_ok;

  always_comb begin
    state_nx       = state;
    x_nx           = x_q;
    dir_nx         = dir_r;
    hp_nx          = hp;
    flash_nx       = flash_cnt;
    hit_pending_nx = frame_tick ? 1'b0 : hit_eff;

    if (frame_tick && enable) begin
      unique case (state)
        PATROL_R: begin
          if (hit_eff) begin
            hp_nx = hp - 4'd1;
            if (hp == 4'd1) begin
              state_nx = DEAD;
            end else begin
              state_nx = HURT;
              flash_nx = FW'(FLASH_FRAMES);
            end
          end else if (({1'b0, x_q} + 11'(SPEED)) >= 11'(X_MAX)) begin
            x_nx     = 10'(X_MAX);
            dir_nx   = 1'b0;
            state_nx = PATROL_L;
          end else begin
            x_nx = x_q + 10'(SPEED);
          end
        end
        PATROL_L: begin
          if (hit_eff) begin
            hp_nx = hp - 4'd1;
            if (hp == 4'd1) begin
              state_nx = DEAD;
            end else begin
              state_nx = HURT;
              flash_nx = FW'(FLASH_FRAMES);
            end
          end else if ({1'b0, x_q} <= (11'(X_MIN) + 11'(SPEED))) begin
            x_nx     = 10'(X_MIN);
            dir_nx   = 1'b1;
            state_nx = PATROL_R;
          end else begin
            x_nx = x_q - 10'(SPEED);
          end
        end
        HURT: begin
          flash_nx = flash_cnt - FW'(1);
          // Leaving on the tick that brings the count to zero.
          if (flash_cnt <= FW'(1)) begin
            flash_nx = '0;
            state_nx = dir_r ? PATROL_R : PATROL_L;
          end
        end
        default: ; // DEAD is terminal until reset
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PATROL_R;
      x_q           <= 10'(X_INIT);
      y_q           <= 10'(Y_INIT);
      dir_r         <= 1'b1;
      hp            <= 4'(HP_INIT);
      flash_cnt     <= '0;
      hit_pending   <= 1'b0;
      cond_q        <= 1'b0;
      cond_qq       <= 1'b0;
      draw_q        <= 1'b0;
      pixel_monster <= 12'h0;
      dead_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      x_q           <= x_nx;
      dir_r         <= dir_nx;
      hp            <= hp_nx;
      flash_cnt     <= flash_nx;
      hit_pending   <= hit_pending_nx;
      cond_q        <= cond;
      cond_qq       <= cond_q;
      // Stage 1 runs alongside the ROM read; stage 2 applies the colour key.
      draw_q        <= in_box && alive && blink_on;
      pixel_monster <= (draw_q && (rom_data != KEY_COLOR)) ? rom_data : 12'h0;
      dead_pulse    <= (state_nx == DEAD) && (state != DEAD);
    end
  end

endmodule
